// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_channel_decoder
// Purpose  : Receive side of one TMDS channel. It takes 10-bit words from a
//            1:10 deserializer at arbitrary bit alignment and finds the symbol
//            boundary by searching for runs of control tokens during blanking.
//            It then decodes each symbol into DE, the 2-bit control value and
//            the 8-bit pixel data.
// Ports    : i_pixel_clk  - pixel clock, one word per cycle
//            i_reset_n    - asynchronous active-low reset
//            i_symbol     - raw deserialized word, bit 0 received first
//            i_resync     - single-cycle pulse, forces a return to search
//            o_locked     - symbol alignment established
//            o_offset     - current bit offset (0..9)
//            o_de         - current symbol is a data symbol
//            o_ctrl       - decoded control bits, held while o_de=1
//            o_data       - decoded pixel byte, 0 while o_de=0
// Revision : 1.0 - initial release
// ============================================================================
module tmds_channel_decoder #(
    parameter int LOCK_TOKENS    = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOSS_TIMEOUT   = 2048
) (
    input  logic       i_pixel_clk,
    input  logic       i_reset_n,
    input  logic [9:0] i_symbol,
    input  logic       i_resync,
    output logic       o_locked,
    output logic [3:0] o_offset,
    output logic       o_de,
    output logic [1:0] o_ctrl,
    output logic [7:0] o_data
);

    localparam logic [0:0]  c_ST_SEARCH    = 1'b0;
    localparam logic [0:0]  c_ST_LOCKED    = 1'b1;
    localparam logic [11:0] c_LOCK_THR     = 12'(LOCK_TOKENS);
    localparam logic [11:0] c_SEARCH_LAST  = 12'(SEARCH_TIMEOUT - 1);
    localparam logic [11:0] c_LOSS_THR     = 12'(LOSS_TIMEOUT);

    logic [0:0]  r_state;
    logic [9:0]  r_prev;
    logic [9:0]  r_sym;
    logic [3:0]  r_offset;
    logic [11:0] r_run;
    logic [11:0] r_timer;
    logic [11:0] r_gap;
    logic        r_skip;
    logic        r_de;
    logic [1:0]  r_ctrl;
    logic [7:0]  r_data;

    logic [18:0] w_cat;
    logic [9:0]  w_aligned;
    logic        w_is_tok;
    logic [1:0]  w_tok_code;
    logic [7:0]  w_t;
    logic [7:0]  w_dec;
    logic [3:0]  w_offset_inc;
    logic [0:0]  w_state_nxt;
    logic [3:0]  w_offset_nxt;
    logic [11:0] w_run_nxt;
    logic [11:0] w_timer_nxt;
    logic [11:0] w_gap_nxt;
    logic        w_skip_nxt;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    // The window never reaches i_symbol[9]; that bit is used next cycle via r_prev.
    assign w_cat = {i_symbol[8:0], r_prev};

    always_comb begin
        w_aligned = w_cat[9:0];
        for (int k = 1; k < 10; k++) begin
            if (r_offset == 4'(k)) begin
                w_aligned = w_cat[k +: 10];
            end
        end
    end

    always_comb begin
        w_is_tok   = 1'b1;
        w_tok_code = 2'b00;
        case (r_sym)
            10'b1101010100: w_tok_code = 2'b00;
            10'b0010101011: w_tok_code = 2'b01;
            10'b0101010100: w_tok_code = 2'b10;
            10'b1010101011: w_tok_code = 2'b11;
            default:        w_is_tok   = 1'b0;
        endcase
    end

    // Undo the transmitter's optional inversion, then its XOR/XNOR chain.
    always_comb begin
        w_t      = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
        w_dec    = 8'd0;
        w_dec[0] = w_t[0];
        for (int i = 1; i < 8; i++) begin
            w_dec[i] = r_sym[8] ? (w_t[i] ^ w_t[i-1]) : ~(w_t[i] ^ w_t[i-1]);
        end
    end

    assign w_offset_inc = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

    // w_skip_nxt marks the cycle after an offset change: the word then in
    // r_sym was aligned under the old offset and must not extend a run.
    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_run_nxt    = r_run;
        w_timer_nxt  = r_timer;
        w_gap_nxt    = r_gap;
        w_skip_nxt   = 1'b0;
        if (i_resync) begin
            w_state_nxt = c_ST_SEARCH;
            w_run_nxt   = 12'd0;
            w_timer_nxt = 12'd0;
            w_gap_nxt   = 12'd0;
        end else if (r_state == c_ST_SEARCH) begin
            if (r_run >= c_LOCK_THR) begin
                w_state_nxt = c_ST_LOCKED;
                w_gap_nxt   = 12'd0;
            end else if (r_timer >= c_SEARCH_LAST) begin
                w_offset_nxt = w_offset_inc;
                w_run_nxt    = 12'd0;
                w_timer_nxt  = 12'd0;
                w_skip_nxt   = 1'b1;
            end else begin
                w_timer_nxt = sat_inc(r_timer);
                w_run_nxt   = (r_skip || !w_is_tok) ? 12'd0 : sat_inc(r_run);
            end
        end else begin
            if (r_gap >= c_LOSS_THR) begin
                w_state_nxt  = c_ST_SEARCH;
                w_offset_nxt = w_offset_inc;
                w_run_nxt    = 12'd0;
                w_timer_nxt  = 12'd0;
                w_gap_nxt    = 12'd0;
                w_skip_nxt   = 1'b1;
            end else begin
                w_gap_nxt = w_is_tok ? 12'd0 : sat_inc(r_gap);
            end
        end
    end

    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= c_ST_SEARCH;
            r_prev   <= 10'd0;
            r_sym    <= 10'd0;
            r_offset <= 4'd0;
            r_run    <= 12'd0;
            r_timer  <= 12'd0;
            r_gap    <= 12'd0;
            r_skip   <= 1'b0;
            r_de     <= 1'b0;
            r_ctrl   <= 2'b00;
            r_data   <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_prev   <= i_symbol;
            r_sym    <= w_aligned;
            r_offset <= w_offset_nxt;
            r_run    <= w_run_nxt;
            r_timer  <= w_timer_nxt;
            r_gap    <= w_gap_nxt;
            r_skip   <= w_skip_nxt;
            // Gating follows the state being entered so outputs open and
            // close on the same edge as o_locked.
            if (w_state_nxt == c_ST_LOCKED) begin
                if (w_is_tok) begin
                    r_de   <= 1'b0;
                    r_ctrl <= w_tok_code;
                    r_data <= 8'd0;
                end else begin
                    r_de   <= 1'b1;
                    r_data <= w_dec;
                end
            end else begin
                r_de   <= 1'b0;
                r_ctrl <= 2'b00;
                r_data <= 8'd0;
            end
        end
    end

    assign o_locked = (r_state == c_ST_LOCKED);
    assign o_offset = r_offset;
    assign o_de     = r_de;
    assign o_ctrl   = r_ctrl;
    assign o_data   = r_data;

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_channel_decoder
// Purpose  : Self-checking bench for tmds_channel_decoder. A bit-level
//            behavioural model is compared with the DUT on every cycle, and
//            directed scenarios add hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_channel_decoder;

    localparam logic [9:0] c_TOK00 = 10'b1101010100;
    localparam logic [9:0] c_TOK01 = 10'b0010101011;
    localparam logic [9:0] c_TOK11 = 10'b1010101011;
    localparam int         c_LOSS  = 2048;
    localparam int         c_SRCH  = 2048;
    localparam int         c_LOCKN = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       resync = 1'b0;
    logic [9:0] sym = 10'd0;
    logic       locked;
    logic [3:0] offset;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;

    int n_vec = 0;
    int n_err = 0;

    tmds_channel_decoder #(
        .LOCK_TOKENS(c_LOCKN), .SEARCH_TIMEOUT(c_SRCH), .LOSS_TIMEOUT(c_LOSS)
    ) dut (
        .i_pixel_clk(clk), .i_reset_n(rst_n), .i_symbol(sym), .i_resync(resync),
        .o_locked(locked), .o_offset(offset), .o_de(de), .o_ctrl(ctrl), .o_data(data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pipeline: last raw word, aligned word awaiting decode, expected outputs.
    logic [9:0] m_last = 10'd0;
    logic [9:0] m_word = 10'd0;
    int  m_locked = 0, m_off = 0, m_run = 0, m_timer = 0, m_gap = 0, m_fresh = 0;
    logic       m_de = 1'b0;
    logic [1:0] m_ctrl = 2'b00;
    logic [7:0] m_data = 8'd0;

    function automatic int token_value(input logic [9:0] q);
        if (q == 10'b1101010100) return 0;
        if (q == 10'b0010101011) return 1;
        if (q == 10'b0101010100) return 2;
        if (q == 10'b1010101011) return 3;
        return -1;
    endfunction

    function automatic logic [7:0] pixel_of(input logic [9:0] q);
        logic [7:0] t;
        logic [7:0] d;
        t = q[9] ? ~q[7:0] : q[7:0];
        d[0] = t[0];
        for (int i = 1; i < 8; i++) d[i] = (t[i] == t[i-1]) ? ~q[8] : q[8];
        return d;
    endfunction

    // The serial bitstream is earlier word then later word; pick 10 bits at off.
    function automatic logic [9:0] pick(input logic [9:0] later, input logic [9:0] earlier, input int off);
        logic [19:0] bits;
        logic [9:0]  w;
        bits = {later, earlier};
        for (int j = 0; j < 10; j++) w[j] = bits[off + j];
        return w;
    endfunction

    function automatic int up(input int v);
        return (v < 4095) ? v + 1 : 4095;
    endfunction

    task automatic model_reset();
        m_last = 0; m_word = 0; m_locked = 0; m_off = 0; m_run = 0;
        m_timer = 0; m_gap = 0; m_fresh = 0; m_de = 0; m_ctrl = 0; m_data = 0;
    endtask

    task automatic model_step();
        logic [9:0] seen;
        int tv;
        int was_fresh;
        seen      = m_word;
        tv        = token_value(seen);
        was_fresh = m_fresh;
        m_fresh   = 0;
        m_word    = pick(sym, m_last, m_off);
        m_last    = sym;
        if (resync) begin
            m_locked = 0; m_run = 0; m_timer = 0; m_gap = 0;
        end else if (m_locked == 0) begin
            if (m_run >= c_LOCKN) begin
                m_locked = 1; m_gap = 0;
            end else if (m_timer >= c_SRCH - 1) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_timer = 0; m_fresh = 1;
            end else begin
                m_timer = up(m_timer);
                m_run   = (was_fresh != 0 || tv < 0) ? 0 : up(m_run);
            end
        end else begin
            if (m_gap >= c_LOSS) begin
                m_locked = 0; m_off = (m_off + 1) % 10;
                m_run = 0; m_timer = 0; m_gap = 0; m_fresh = 1;
            end else begin
                m_gap = (tv >= 0) ? 0 : up(m_gap);
            end
        end
        if (m_locked == 0) begin
            m_de = 0; m_ctrl = 0; m_data = 0;
        end else if (tv >= 0) begin
            m_de = 0; m_ctrl = 2'(tv); m_data = 0;
        end else begin
            m_de = 1; m_data = pixel_of(seen);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step();
                #1;
                if (rst_n) begin
                    chk("cyc_locked", 16'(locked), 16'(m_locked));
                    chk("cyc_offset", 16'(offset), 16'(m_off));
                    chk("cyc_de",     16'(de),     16'(m_de));
                    chk("cyc_ctrl",   16'(ctrl),   16'(m_ctrl));
                    chk("cyc_data",   16'(data),   16'(m_data));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic [9:0] w);
        @(negedge clk);
        sym = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; sym = 10'd0; resync = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int first;
        int c;
        logic [9:0] t01;
        logic [9:0] rot01;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_locked", 16'(locked), 16'd0);
        chk("rst_offset", 16'(offset), 16'd0);
        chk("rst_de", 16'(de), 16'd0);
        chk("rst_ctrl", 16'(ctrl), 16'd0);
        chk("rst_data", 16'(data), 16'd0);
        rst_n = 1'b1;

        // aligned lock: first observed at the 12th negedge (lock edge n+10)
        first = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (locked && first == 0) first = i;
            sym = c_TOK00;
        end
        chk("lock_at", 16'(first), 16'd12);
        step(c_TOK00);
        chk("lock_locked", 16'(locked), 16'd1);
        chk("lock_offset", 16'(offset), 16'd0);
        chk("lock_ctrl", 16'(ctrl), 16'd0);
        chk("lock_de", 16'(de), 16'd0);

        // data decode, three cycles after input
        step(10'h100); step(10'h2FF); step(c_TOK11); step(c_TOK00);
        chk("dec100_de", 16'(de), 16'd1);
        chk("dec100_data", 16'(data), 16'h00);
        step(c_TOK00);
        chk("dec2ff_de", 16'(de), 16'd1);
        chk("dec2ff_data", 16'(data), 16'hFE);
        step(c_TOK00);
        chk("tok11_de", 16'(de), 16'd0);
        chk("tok11_ctrl", 16'(ctrl), 16'd3);

        // 2047 data symbols then a token: lock must hold
        repeat (c_LOSS - 1) step(10'h100);
        repeat (5) step(c_TOK00);
        chk("short_gap_locked", 16'(locked), 16'd1);

        // loss of lock: falls at the 2052nd negedge of the data run
        first = 0;
        for (int i = 1; i <= 2100; i++) begin
            @(negedge clk);
            if (!locked) begin
                first = i;
                break;
            end
            sym = 10'h100;
        end
        chk("loss_at", 16'(first), 16'd2052);
        chk("loss_offset", 16'(offset), 16'd1);

        // asynchronous reset while locked and showing data
        do_reset();
        repeat (16) step(c_TOK00);
        repeat (4) step(10'h2FF);
        chk("pre_rst_de", 16'(de), 16'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_locked", 16'(locked), 16'd0);
        chk("arst_de", 16'(de), 16'd0);
        chk("arst_data", 16'(data), 16'd0);
        chk("arst_ctrl", 16'(ctrl), 16'd0);
        @(negedge clk);
        rst_n = 1'b1; sym = 10'd0;
        @(negedge clk);
        chk("rel_locked", 16'(locked), 16'd0);
        chk("rel_offset", 16'(offset), 16'd0);

        // resync sampled on the edge where run reaches 8
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i >= 12) begin
                chk("resync_locked", 16'(locked), 16'd0);
                chk("resync_offset", 16'(offset), 16'd0);
            end
            sym = c_TOK00;
            resync = (i == 10);
        end
        resync = 1'b0;

        // misaligned stream: ctrl-01 tokens shifted by 3 bits
        t01 = c_TOK01;
        rot01 = {t01[6:0], t01[9:7]};
        do_reset();
        c = 0;
        while (c < 3 * c_SRCH + 16 && !locked) begin
            step(rot01);
            c++;
        end
        chk("mis_locked", 16'(locked), 16'd1);
        chk("mis_offset", 16'(offset), 16'd3);
        repeat (4) step(rot01);
        chk("mis_ctrl", 16'(ctrl), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
